magnitude_sequencer: RTL and testbench

//  Sequencer for the Avalon master port of the magnitude accelerator. Takes one job
//  (src addr, dst addr, length) from the control interface. Per element: commands the

---
 rtl/magnitude_sequencer_pkg.sv | 25 ++
 rtl/magnitude_sequencer_if.sv | 25 ++
 rtl/magnitude_sequencer_mag_sq_unit.sv | 35 +++
 rtl/magnitude_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_magnitude_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/magnitude_sequencer_pkg.sv
// Shared definitions for the magnitude accelerator sequencer.
//   - FSM state encoding
//   - word geometry (bytes per word, x/y field placement inside a data word)
package magnitude_sequencer_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = 2;   // log2(WORD_BYTES): element index -> byte offset
    localparam int FIELD_W    = 16;  // width of each signed x / y field
    localparam int X_LSB      = 0;
    localparam int Y_LSB      = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CALC,
        ST_RDROP,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_WDROP,
        ST_FIN,
        ST_ABORT
    } seq_state_e;

endpackage

// File: rtl/magnitude_sequencer_if.sv
// Request/response bundle between the sequencer and the Avalon master engine.
//   master modport : sequencer side (issues requests, receives completion)
//   slave  modport : master-engine side (executes requests, signals MST_DONE)
interface magnitude_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              MST_START;
    logic              MST_READ_REQ;
    logic              MST_WRITE_REQ;
    logic [ADDR_W-1:0] MST_ADDRESS;
    logic [DATA_W-1:0] MST_WRITE_DATA;
    logic [DATA_W-1:0] MST_READ_DATA;
    logic              MST_DONE;

    modport master (
        output MST_START, MST_READ_REQ, MST_WRITE_REQ, MST_ADDRESS, MST_WRITE_DATA,
        input  MST_READ_DATA, MST_DONE
    );

    modport slave (
        input  MST_START, MST_READ_REQ, MST_WRITE_REQ, MST_ADDRESS, MST_WRITE_DATA,
        output MST_READ_DATA, MST_DONE
    );
endinterface

// File: rtl/magnitude_sequencer_mag_sq_unit.sv
// mag_sq_unit: registered x*x + y*y of one packed element word.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   en     : load a new result this cycle (one-cycle latency)
//   word   : {y[15:0], x[15:0]}, both signed
//   result : unsigned sum of squares, held until the next enable
module mag_sq_unit
    import magnitude_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] word,
    output logic [31:0] result
);
    logic [31:0]        result_q, result_d;
    logic signed [31:0] x_ext, y_ext, x_sq, y_sq;

    // Each square is at most 2^30, so a 32-bit signed product is exact; the sum
    // peaks at 2^31 which is only representable as unsigned, hence the final cast.
    always_comb begin
        x_ext    = {{(32-FIELD_W){word[X_LSB+FIELD_W-1]}}, word[X_LSB +: FIELD_W]};
        y_ext    = {{(32-FIELD_W){word[Y_LSB+FIELD_W-1]}}, word[Y_LSB +: FIELD_W]};
        x_sq     = x_ext * x_ext;
        y_sq     = y_ext * y_ext;
        result_d = en ? ($unsigned(x_sq) + $unsigned(y_sq)) : result_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) result_q <= '0;
        else        result_q <= result_d;
    end

    assign result = result_q;
endmodule

// File: rtl/magnitude_sequencer.sv
// magnitude_sequencer: walks one job of LEN elements; for each element reads a
// word through the master, squares-and-sums it, and writes the result back.
//   CSI_CLOCK_CLK / CSI_CLOCK_RESET_N : clock, synchronous active-low reset
//   CFG_START/SRC_ADDR/DST_ADDR/LEN   : job launch, sampled only when idle
//   BUSY / DONE / ERROR / ELEM_CNT    : job status (DONE, ERROR sticky)
//   mst                               : request/response bundle to the master
module magnitude_sequencer
    import magnitude_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              CSI_CLOCK_CLK,
    input  logic              CSI_CLOCK_RESET_N,
    input  logic              CFG_START,
    input  logic [ADDR_W-1:0] CFG_SRC_ADDR,
    input  logic [ADDR_W-1:0] CFG_DST_ADDR,
    input  logic [LEN_W-1:0]  CFG_LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [LEN_W-1:0]  ELEM_CNT,
    magnitude_sequencer_if.master mst
);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d, elem_cnt_q, elem_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              start_q, start_d, rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic              expired;
    logic [31:0]       result;

    mag_sq_unit u_mag_sq (
        .clk    (CSI_CLOCK_CLK),
        .rst_n  (CSI_CLOCK_RESET_N),
        .en     (state_q == ST_CALC),
        .word   (rdata_q[31:0]),
        .result (result)
    );

    assign expired = (timer_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        elem_cnt_d = elem_cnt_q;
        rdata_d    = rdata_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        start_d    = 1'b0;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        // Timer restarts on every state change; it only advances while parked
        // in a wait/drop state, so each wait phase gets a full timeout budget.
        timer_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (CFG_START) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    elem_cnt_d = '0;
                    idx_d      = '0;
                    src_d      = CFG_SRC_ADDR;
                    dst_d      = CFG_DST_ADDR;
                    len_d      = CFG_LEN;
                    busy_d     = 1'b1;
                    state_d    = (CFG_LEN == '0) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mst.MST_DONE) begin
                    rdata_d = mst.MST_READ_DATA;
                    state_d = ST_CALC;
                end else if (expired) begin
                    state_d = ST_ABORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CALC: state_d = ST_RDROP;
            ST_RDROP: begin
                if (!mst.MST_DONE)  state_d = ST_WR_REQ;
                else if (expired)   state_d = ST_ABORT;
                else                timer_d = timer_q + 1'b1;
            end
            ST_WR_REQ: state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (mst.MST_DONE) begin
                    elem_cnt_d = elem_cnt_q + 1'b1;
                    idx_d      = idx_q + 1'b1;
                    state_d    = ST_WDROP;
                end else if (expired) begin
                    state_d = ST_ABORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WDROP: begin
                if (!mst.MST_DONE)  state_d = (idx_q == len_q) ? ST_FIN : ST_RD_REQ;
                else if (expired)   state_d = ST_ABORT;
                else                timer_d = timer_q + 1'b1;
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Request outputs are registered: they are prepared from the next state
        // so they appear exactly while the FSM sits in the *_REQ state. Address
        // and write data then hold until the following request.
        if (state_d == ST_RD_REQ) begin
            start_d  = 1'b1;
            rd_req_d = 1'b1;
            addr_d   = src_d + (ADDR_W'(idx_d) << WORD_SHIFT);
        end else if (state_d == ST_WR_REQ) begin
            start_d  = 1'b1;
            wr_req_d = 1'b1;
            addr_d   = dst_d + (ADDR_W'(idx_d) << WORD_SHIFT);
            wdata_d  = DATA_W'(result);
        end
    end

    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (!CSI_CLOCK_RESET_N) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            elem_cnt_q <= '0;
            timer_q    <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            start_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            elem_cnt_q <= elem_cnt_d;
            timer_q    <= timer_d;
            rdata_q    <= rdata_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            start_q    <= start_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
        end
    end

    assign BUSY               = busy_q;
    assign DONE               = done_q;
    assign ERROR              = error_q;
    assign ELEM_CNT           = elem_cnt_q;
    assign mst.MST_START      = start_q;
    assign mst.MST_READ_REQ   = rd_req_q;
    assign mst.MST_WRITE_REQ  = wr_req_q;
    assign mst.MST_ADDRESS    = addr_q;
    assign mst.MST_WRITE_DATA = wdata_q;
endmodule

// File: tb/tb_magnitude_sequencer.sv
// Directed bench for magnitude_sequencer with a behavioural master model and a
// scoreboard queue of expected writes.
module tb_magnitude_sequencer;
    localparam int TIMEOUT = 64;
    localparam int PERIOD  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [31:0] cfg_src, cfg_dst;
    logic [15:0] cfg_len;
    logic        busy, done, error;
    logic [15:0] elem_cnt;

    magnitude_sequencer_if #(.DATA_W(32), .ADDR_W(32)) mst_bus ();

    magnitude_sequencer #(
        .DATA_W(32), .ADDR_W(32), .LEN_W(16), .TIMEOUT(TIMEOUT)
    ) dut (
        .CSI_CLOCK_CLK     (clk),
        .CSI_CLOCK_RESET_N (rst_n),
        .CFG_START         (cfg_start),
        .CFG_SRC_ADDR      (cfg_src),
        .CFG_DST_ADDR      (cfg_dst),
        .CFG_LEN           (cfg_len),
        .BUSY              (busy),
        .DONE              (done),
        .ERROR             (error),
        .ELEM_CNT          (elem_cnt),
        .mst               (mst_bus)
    );

    always #(PERIOD/2) clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          starts = 0;
    int          reads  = 0;
    int          drop_read = -1;
    int          lat = 0;
    time         drop_time = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] w);
        longint x, y;
        x = longint'($signed(w[15:0]));
        y = longint'($signed(w[31:16]));
        return 32'(x * x + y * y);
    endfunction

    // Master model: one outstanding request, MST_DONE pulses for one cycle
    // after `lat` wait cycles; a chosen read can be left unanswered.
    logic        pending = 1'b0;
    logic        pend_read;
    logic [31:0] pend_addr;
    int          cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
            mst_bus.MST_DONE = 1'b0;
            mst_bus.MST_READ_DATA = '0;
        end else begin
            if (mst_bus.MST_DONE) begin
                mst_bus.MST_DONE = 1'b0;
            end else if (pending) begin
                if (cnt == 0) begin
                    mst_bus.MST_DONE = 1'b1;
                    if (pend_read)
                        mst_bus.MST_READ_DATA = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mst_bus.MST_START) begin
                starts++;
                check("rw_exclusive", 64'(mst_bus.MST_READ_REQ & mst_bus.MST_WRITE_REQ), 64'd0);
                if (mst_bus.MST_READ_REQ) begin
                    $display("rd addr=%08h", mst_bus.MST_ADDRESS);
                    if (reads == drop_read) begin
                        drop_time = $time;
                    end else begin
                        pending = 1'b1; cnt = lat; pend_read = 1'b1;
                        pend_addr = mst_bus.MST_ADDRESS;
                    end
                    reads++;
                end else begin
                    $display("wr addr=%08h data=%08h", mst_bus.MST_ADDRESS, mst_bus.MST_WRITE_DATA);
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", 64'(mst_bus.MST_ADDRESS), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(mst_bus.MST_ADDRESS), 64'(e.addr));
                        check("wr_data", 64'(mst_bus.MST_WRITE_DATA), 64'(e.data));
                    end
                    pending = 1'b1; cnt = lat; pend_read = 1'b0;
                    pend_addr = mst_bus.MST_ADDRESS;
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        cfg_src = s; cfg_dst = d; cfg_len = l; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int bound);
        int n;
        n = 0;
        while (!(done || error) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < bound), 64'd1);
    endtask

    initial begin
        int   s0;
        time  err_t;
        int   delta;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_elem_cnt", 64'(elem_cnt), 64'd0);
        check("rst_mst_start", 64'(mst_bus.MST_START), 64'd0);
        rst_n = 1'b1;

        // Single element: 3^2 + 4^2 = 25.
        mem[32'h100] = 32'h0004_0003;
        push_exp(32'h200, 32'h19);
        lat = 0;
        start_job(32'h100, 32'h200, 16'd1);
        check("t1_busy", 64'(busy), 64'd1);
        wait_end("t1_end", 200);
        check("t1_done", 64'(done), 64'd1);
        check("t1_error", 64'(error), 64'd0);
        check("t1_cnt", 64'(elem_cnt), 64'd1);

        // Four elements, including the 2^31 extreme.
        mem[32'h300] = 32'hFFFF_0001;
        mem[32'h304] = 32'h8000_8000;
        mem[32'h308] = 32'h0000_0000;
        mem[32'h30C] = 32'h0000_0007;
        push_exp(32'h400, 32'd2);
        push_exp(32'h404, 32'h8000_0000);
        push_exp(32'h408, 32'd0);
        push_exp(32'h40C, 32'd49);
        lat = 2;
        start_job(32'h300, 32'h400, 16'd4);
        check("t2_done_cleared", 64'(done), 64'd0);
        wait_end("t2_end", 400);
        check("t2_done", 64'(done), 64'd1);
        check("t2_cnt", 64'(elem_cnt), 64'd4);
        check("t2_queue", 64'(exp_q.size()), 64'd0);

        // Empty job: no master traffic, DONE two cycles after the start pulse.
        s0 = starts;
        start_job(32'h500, 32'h600, 16'd0);
        check("t0_done_early", 64'(done), 64'd0);
        @(negedge clk);
        check("t0_done", 64'(done), 64'd1);
        check("t0_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("t0_no_start", 64'(starts - s0), 64'd0);
        check("t0_cnt", 64'(elem_cnt), 64'd0);

        // Second read never completes -> timeout abort after one element.
        mem[32'h1000] = 32'h0002_0001;
        mem[32'h1004] = 32'h0001_0001;
        push_exp(32'h2000, mag(32'h0002_0001));
        lat = 1;
        drop_read = reads + 1;
        start_job(32'h1000, 32'h2000, 16'd3);
        wait_end("to_end", 4 * TIMEOUT);
        err_t = $time;
        delta = int'((err_t - drop_time) / PERIOD);
        check("to_error", 64'(error), 64'd1);
        check("to_done", 64'(done), 64'd0);
        check("to_cnt", 64'(elem_cnt), 64'd1);
        check("to_window", 64'(delta >= TIMEOUT && delta <= TIMEOUT + 2), 64'd1);
        drop_read = -1;

        // CFG_START with a different job while busy must be ignored.
        mem[32'h3000] = 32'h0005_FFFD;
        mem[32'h3004] = 32'hFFF0_000C;
        push_exp(32'h4000, mag(32'h0005_FFFD));
        push_exp(32'h4004, mag(32'hFFF0_000C));
        s0 = starts;
        lat = 3;
        start_job(32'h3000, 32'h4000, 16'd2);
        check("mj_error_cleared", 64'(error), 64'd0);
        repeat (3) @(negedge clk);
        cfg_src = 32'h9000; cfg_dst = 32'hA000; cfg_len = 16'd5; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_end("mj_end", 400);
        check("mj_done", 64'(done), 64'd1);
        check("mj_cnt", 64'(elem_cnt), 64'd2);
        check("mj_starts", 64'(starts - s0), 64'd4);
        check("mj_queue", 64'(exp_q.size()), 64'd0);

        // Reset while waiting on a write: everything clears, no more requests.
        mem[32'h5000] = 32'h0001_0002;
        push_exp(32'h6000, mag(32'h0001_0002));
        lat = 5;
        start_job(32'h5000, 32'h6000, 16'd2);
        begin
            int n;
            n = 0;
            while (!(mst_bus.MST_START && mst_bus.MST_WRITE_REQ) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rs_wr_seen", 64'(n < 200), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_done", 64'(done), 64'd0);
        check("rs_cnt", 64'(elem_cnt), 64'd0);
        check("rs_mst_start", 64'(mst_bus.MST_START), 64'd0);
        check("rs_mst_addr", 64'(mst_bus.MST_ADDRESS), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = starts;
        repeat (30) @(negedge clk);
        check("rs_no_start", 64'(starts - s0), 64'd0);
        check("rs_busy_after", 64'(busy), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
